// File: rtl/traffic_light_ctrl_pkg.sv
// Shared encodings for the traffic light controller: phase states, unit sub-states, lamp codes.
// The optional pedestrian walk phase is enabled with the TL_PED_WALK_EN macro.
package traffic_light_ctrl_pkg;

  typedef enum logic [2:0] {
    S_ALLRED_B  = 3'd0,
    S_NS_GREEN  = 3'd1,
    S_NS_YELLOW = 3'd2,
    S_ALLRED_A  = 3'd3,
    S_EW_GREEN  = 3'd4,
    S_EW_YELLOW = 3'd5,
    S_WALK      = 3'd6
  } state_e;

  typedef enum logic {
    SUB_ARM = 1'b0,
    SUB_RUN = 1'b1
  } sub_e;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

endpackage

// File: rtl/tl_unit_cnt.sv
// Unit counter for one traffic-light phase: clears on phase change, increments per expired
// timer unit, and flags when the parent-selected terminal value is reached.
module tl_unit_cnt #(
  parameter int unsigned UNIT_BITS = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic [UNIT_BITS-1:0] term_i,
  output logic                 at_term_o
);

  logic [UNIT_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_term_o = (cnt_q == term_i);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection phase sequencer driven by an external restartable timer.
// Define TL_PED_WALK_EN to add a latched pedestrian request and a WALK phase after EW_YELLOW.
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int unsigned GREEN_UNITS  = 3,
  parameter int unsigned YELLOW_UNITS = 1,
  parameter int unsigned ALLRED_UNITS = 1,
  parameter int unsigned WALK_UNITS   = 2,
  parameter int unsigned UNIT_BITS    = 4
) (
  input  logic       clk,
  input  logic       r,
  input  logic       tick,
  input  logic       tmr_done,
  output logic       tmr_r,
  output logic       tmr_en,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk
);

  localparam logic [UNIT_BITS-1:0] GreenTerm  = UNIT_BITS'(GREEN_UNITS - 1);
  localparam logic [UNIT_BITS-1:0] YellowTerm = UNIT_BITS'(YELLOW_UNITS - 1);
  localparam logic [UNIT_BITS-1:0] AllredTerm = UNIT_BITS'(ALLRED_UNITS - 1);
  localparam logic [UNIT_BITS-1:0] WalkTerm   = UNIT_BITS'(WALK_UNITS - 1);

  state_e               state_q, state_d, next_phase;
  sub_e                 sub_q, sub_d;
  logic [2:0]           ns_q, ns_d, ew_q, ew_d;
  logic                 walk_q, walk_d;
  logic                 tmr_r_q, tmr_r_d;
  logic [UNIT_BITS-1:0] term;
  logic                 at_term, unit_done, cnt_clr, cnt_inc;

`ifdef TL_PED_WALK_EN
  logic ped_pend_q, ped_pend_d;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  // Only a done seen while running counts; done during ARM or reset is dropped.
  assign unit_done = (sub_q == SUB_RUN) && tmr_done;
  assign cnt_clr   = unit_done && at_term;
  assign cnt_inc   = unit_done && !at_term;

  always_comb begin
    case (state_q)
      S_NS_GREEN, S_EW_GREEN:   term = GreenTerm;
      S_NS_YELLOW, S_EW_YELLOW: term = YellowTerm;
      S_WALK:                   term = WalkTerm;
      default:                  term = AllredTerm;
    endcase
  end

  tl_unit_cnt #(
    .UNIT_BITS (UNIT_BITS)
  ) u_unit_cnt (
    .clk_i     (clk),
    .rst_i     (r),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .term_i    (term),
    .at_term_o (at_term)
  );

  always_comb begin
    case (state_q)
      S_ALLRED_B:  next_phase = S_NS_GREEN;
      S_NS_GREEN:  next_phase = S_NS_YELLOW;
      S_NS_YELLOW: next_phase = S_ALLRED_A;
      S_ALLRED_A:  next_phase = S_EW_GREEN;
      S_EW_GREEN:  next_phase = S_EW_YELLOW;
      S_EW_YELLOW: begin
        next_phase = S_ALLRED_B;
`ifdef TL_PED_WALK_EN
        if (ped_pend_q) begin
          next_phase = S_WALK;
        end
`endif
      end
      default:     next_phase = S_ALLRED_B;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    if (sub_q == SUB_ARM) begin
      sub_d = SUB_RUN;
    end else if (tmr_done) begin
      sub_d = SUB_ARM;
      if (at_term) begin
        state_d = next_phase;
      end
    end
  end

`ifdef TL_PED_WALK_EN
  // A request arriving on the WALK-entry cycle survives the clear and earns another walk.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (state_d == S_WALK && state_q != S_WALK) begin
      ped_pend_d = 1'b0;
    end
    if (ped_req && state_q != S_WALK) begin
      ped_pend_d = 1'b1;
    end
  end
`endif

  // Lamps are decoded from the next state and registered, so they only change on a phase edge.
  always_comb begin
    ns_d    = L_RED;
    ew_d    = L_RED;
    walk_d  = 1'b0;
    tmr_r_d = (sub_d == SUB_ARM);
    case (state_d)
      S_NS_GREEN:  ns_d = L_GRN;
      S_NS_YELLOW: ns_d = L_YEL;
      S_EW_GREEN:  ew_d = L_GRN;
      S_EW_YELLOW: ew_d = L_YEL;
`ifdef TL_PED_WALK_EN
      S_WALK:      walk_d = 1'b1;
`endif
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q    <= S_ALLRED_B;
      sub_q      <= SUB_ARM;
      ns_q       <= L_RED;
      ew_q       <= L_RED;
      walk_q     <= 1'b0;
      tmr_r_q    <= 1'b1;
`ifdef TL_PED_WALK_EN
      ped_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
      walk_q     <= walk_d;
      tmr_r_q    <= tmr_r_d;
`ifdef TL_PED_WALK_EN
      ped_pend_q <= ped_pend_d;
`endif
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign walk     = walk_q;
  assign tmr_r    = tmr_r_q;
  assign tmr_en   = tick && !tmr_r_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: a table of phases expands into per-cycle expectations that a
// scoreboard compares on the falling edge. Honours TL_PED_WALK_EN like the design.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       r, tick, tmr_done, ped_req, tmr_r, tmr_en, walk, force_done;
  logic [2:0] ns_light, ew_light;
  logic [1:0] tcnt;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  always #5 clk = ~clk;

  traffic_light_ctrl dut (
    .clk      (clk),
    .r        (r),
    .tick     (tick),
    .tmr_done (tmr_done),
    .tmr_r    (tmr_r),
    .tmr_en   (tmr_en),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk)
  );

  // Timer model: done appears on the third enabled cycle after restart and holds until restart.
  always @(posedge clk or posedge r) begin
    if (r) tcnt <= 2'd0;
    else if (tmr_r) tcnt <= 2'd0;
    else if (tmr_en && tcnt != 2'd2) tcnt <= tcnt + 2'd1;
  end
  assign tmr_done = force_done || (tcnt == 2'd2);

  typedef struct {
    string      tag;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
    logic       tr;
    logic       te;
  } exp_t;

  typedef struct {
    string      nm;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       wk;
    int         units;
    int         stall_unit;
    int         stall_len;
    int         ped_unit;
    int         rst_unit;
    bit         hold;
  } row_t;

  exp_t q[$];
  row_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (ns_light !== e.ns || ew_light !== e.ew || walk !== e.wk || tmr_r !== e.tr ||
          tmr_en !== e.te) begin
        errors++;
        $display("FAIL %s t=%0t: got ns=%b ew=%b walk=%b tmr_r=%b tmr_en=%b want ns=%b ew=%b walk=%b tmr_r=%b tmr_en=%b",
                 e.tag, $time, ns_light, ew_light, walk, tmr_r, tmr_en,
                 e.ns, e.ew, e.wk, e.tr, e.te);
      end
    end
  end

  // One clock cycle: drive inputs just after the rising edge and queue what must be seen.
  task automatic cyc(input logic rv, input logic tk, input logic pd, input logic fd,
                     input string tag, input logic [2:0] ns, input logic [2:0] ew,
                     input logic wk, input logic tr, input logic te);
    exp_t e;
    @(posedge clk);
    #1;
    r = rv; tick = tk; ped_req = pd; force_done = fd;
    e.tag = tag; e.ns = ns; e.ew = ew; e.wk = wk; e.tr = tr; e.te = te;
    q.push_back(e);
  endtask

  task automatic add(input string nm, input logic [2:0] ns, input logic [2:0] ew,
                     input logic wk, input int units, input int stall_unit, input int stall_len,
                     input int ped_unit, input int rst_unit, input bit hold);
    row_t rw;
    rw.nm = nm; rw.ns = ns; rw.ew = ew; rw.wk = wk; rw.units = units;
    rw.stall_unit = stall_unit; rw.stall_len = stall_len; rw.ped_unit = ped_unit;
    rw.rst_unit = rst_unit; rw.hold = hold;
    tbl.push_back(rw);
  endtask

  // A unit is one ARM cycle then RUN cycles until done: 3 with the timer model, 1 if done is held.
  task automatic run_phase(input row_t rw);
    for (int u = 0; u < rw.units; u++) begin
      cyc(1'b0, 1'b1, u == rw.ped_unit, rw.hold, {rw.nm, "/arm"}, rw.ns, rw.ew, rw.wk,
          1'b1, 1'b0);
      if (u == rw.stall_unit)
        repeat (rw.stall_len) cyc(1'b0, 1'b0, 1'b0, rw.hold, {rw.nm, "/stall"}, rw.ns, rw.ew,
                                  rw.wk, 1'b0, 1'b0);
      if (u == rw.rst_unit) begin
        cyc(1'b0, 1'b1, 1'b0, 1'b0, {rw.nm, "/run"}, rw.ns, rw.ew, rw.wk, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, {rw.nm, "/reset"}, RED, RED, 1'b0, 1'b1, 1'b0);
        return;
      end
      repeat (rw.hold ? 1 : 3) cyc(1'b0, 1'b1, 1'b0, rw.hold, {rw.nm, "/run"}, rw.ns, rw.ew,
                                   rw.wk, 1'b0, 1'b1);
    end
  endtask

  initial begin
    r = 1'b1; tick = 1'b1; ped_req = 1'b0; force_done = 1'b0;
    // name, ns, ew, walk, units, stall_unit, stall_len, ped_unit, rst_unit, hold
    add("allred_b", RED, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("ns_green", GRN, RED, 1'b0, 3, -1, 0, -1, -1, 1'b0);
    add("ns_yel",   YEL, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("allred_a", RED, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("ew_green", RED, GRN, 1'b0, 3, -1, 0, -1, -1, 1'b0);
    add("ew_yel",   RED, YEL, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("allred_b", RED, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("ns_g_stl", GRN, RED, 1'b0, 3, 1, 10, -1, -1, 1'b0);
    add("ns_yel",   YEL, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("allred_a", RED, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("ew_green", RED, GRN, 1'b0, 3, -1, 0, -1, -1, 1'b0);
    add("ew_yel",   RED, YEL, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("allred_b", RED, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("ns_g_hld", GRN, RED, 1'b0, 3, -1, 0, -1, -1, 1'b1);
    add("ns_yel",   YEL, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("allred_a", RED, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("ew_g_rst", RED, GRN, 1'b0, 3, -1, 0, -1, 1, 1'b0);
    add("allred_b", RED, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("ns_g_ped", GRN, RED, 1'b0, 3, -1, 0, 1, -1, 1'b0);
    add("ns_yel",   YEL, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("allred_a", RED, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("ew_green", RED, GRN, 1'b0, 3, -1, 0, -1, -1, 1'b0);
    add("ew_yel",   RED, YEL, 1'b0, 1, -1, 0, -1, -1, 1'b0);
`ifdef TL_PED_WALK_EN
    add("walk",     RED, RED, 1'b1, 2, -1, 0, 1, -1, 1'b0);
`endif
    add("allred_b", RED, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("ns_green", GRN, RED, 1'b0, 3, -1, 0, -1, -1, 1'b0);
    add("ns_yel",   YEL, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("allred_a", RED, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("ew_green", RED, GRN, 1'b0, 3, -1, 0, -1, -1, 1'b0);
    add("ew_yel",   RED, YEL, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("allred_b", RED, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);
    add("ns_green", GRN, RED, 1'b0, 1, -1, 0, -1, -1, 1'b0);

    // Held reset: all red, timer restart asserted, timer disabled despite tick=1.
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, "reset", RED, RED, 1'b0, 1'b1, 1'b0);
    // A done asserted during reset must not be queued into the first unit.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, "reset_done", RED, RED, 1'b0, 1'b1, 1'b0);

    foreach (tbl[i]) run_phase(tbl[i]);

    // Let the last queued expectation be compared before summarising.
    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
